// File: rtl/clock_pkg.sv
// Mode encodings shared by the clock mode controller and the display mux.
package clock_pkg;

  localparam int unsigned ModeW = 2;

  localparam logic [ModeW-1:0] MODE_RUN      = 2'b00;
  localparam logic [ModeW-1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [ModeW-1:0] MODE_SET_MIN  = 2'b10;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchronizer, stability debounce and a
// registered one-cycle pulse on each debounced press.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q, deb_prev_d;
  logic            press_q, press_d;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    cnt_d      = '0;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
    // Count cycles the synced level has differed from the accepted level;
    // any return to the accepted level restarts the count.
    if (sync2_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Digital-clock mode controller: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN FSM,
// set-mode blink and one-cycle counter increment/clear pulses.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hour_inc,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PrescW = $clog2(CLK_HZ);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_HZ - 1);
  localparam logic [PrescW-1:0] BlinkMax = PrescW'(CLK_HZ / 2 - 1);

  logic              mode_press, inc_press;
  logic [1:0]        mode_q, mode_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [PrescW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic              sec_clr_q, sec_clr_d;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_mode (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_mode),
    .press  (mode_press)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_inc (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_inc),
    .press  (inc_press)
  );

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:      if (mode_press) mode_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_press) mode_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_press) mode_d = MODE_RUN;
      default:       mode_d = MODE_RUN;
    endcase
  end

  always_comb begin
    // Only counts while staying in RUN, so a fresh RUN entry starts from 0.
    if (mode_q == MODE_RUN && mode_d == MODE_RUN) begin
      presc_d = (presc_q == PrescMax) ? '0 : presc_q + PrescW'(1);
    end else begin
      presc_d = '0;
    end

    if (mode_d == MODE_RUN || mode_d != mode_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + PrescW'(1);
      blink_d     = blink_q;
    end

    sec_clr_d = (mode_q == MODE_SET_MIN) && mode_press;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  // Pulses decode registered state only; a mode press swallows a coincident inc press.
  assign sec_tick = (mode_q == MODE_RUN) && (presc_q == PrescMax);
  assign sec_clr  = sec_clr_q;
  assign hour_inc = inc_press && !mode_press && (mode_q == MODE_SET_HOUR);
  assign min_inc  = inc_press && !mode_press && (mode_q == MODE_SET_MIN);
  assign mode     = mode_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl with CLK_HZ=10, DEBOUNCE_CYCLES=3.
module tb_clock_mode_ctrl;

  localparam logic [3:0] KTick = 4'b1000;
  localparam logic [3:0] KClr  = 4'b0100;
  localparam logic [3:0] KMin  = 4'b0010;
  localparam logic [3:0] KHour = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_tick;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic [1:0] mode;
  logic       blink;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [3:0] mon_got;

  clock_mode_ctrl #(
    .CLK_HZ         (10),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .sec_tick(sec_tick),
    .sec_clr (sec_clr),
    .min_inc (min_inc),
    .hour_inc(hour_inc),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the falling edge at which the cycle counter equals t.
  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] k);
    exp_q.push_back('{cyc: c, kind: k});
  endtask

  initial begin
    int r, c, d, e, f, g, h, m, n, p, q, rr;

    fork
      forever begin
        @(negedge clk);
        mon_got = {sec_tick, sec_clr, min_inc, hour_inc};
        if (mon_got != 4'b0000) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", mon_got, cyc);
          end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.cyc != cyc || mon_ev.kind != mon_got) begin
              n_fail++;
              $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                       mon_got, cyc, mon_ev.kind, mon_ev.cyc);
            end
          end
        end
      end
    join_none

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #2 reset = 1'b0;

    // 1: reset state, then idle RUN with a tick every 10 cycles after release
    at(3);
    check("reset_mode", mode, 2'b00);
    check("reset_blink", blink, 1'b0);
    check("reset_pulses", {sec_tick, sec_clr, min_inc, hour_inc}, 4'b0000);
    at(4);
    reset = 1'b1;
    r = cyc;
    // cycle r is the first cycle after release, so the 10th cycle is r+9
    for (int k = 1; k <= 4; k++) expect_pulse(r + 10 * k - 1, KTick);
    check("run_mode_after_release", mode, 2'b00);

    // 2: mode press -> SET_HOUR; ticks stop; blink toggles every 5 cycles
    c = r + 35;
    at(c);
    btn_mode = 1'b1;
    at(c + 6);
    check("mode_before_press_edge", mode, 2'b00);
    at(c + 7);
    check("mode_set_hour", mode, 2'b01);
    check("blink_on_entry", blink, 1'b0);
    at(c + 8);
    btn_mode = 1'b0;
    at(c + 11);
    check("blink_c4", blink, 1'b0);
    at(c + 12);
    check("blink_c5", blink, 1'b1);
    at(c + 16);
    check("blink_c9", blink, 1'b1);
    at(c + 17);
    check("blink_c10", blink, 1'b0);

    // 3: one-cycle inc glitch ignored, 6-cycle press gives one hour_inc
    d = c + 20;
    at(d);
    btn_inc = 1'b1;
    at(d + 1);
    btn_inc = 1'b0;
    e = d + 6;
    expect_pulse(e + 6, KHour);
    at(e);
    btn_inc = 1'b1;
    at(e + 6);
    btn_inc = 1'b0;
    f = e + 14;
    at(f);
    btn_mode = 1'b1;
    at(f + 6);
    btn_mode = 1'b0;
    at(f + 7);
    check("mode_set_min", mode, 2'b10);

    // 4: two min_inc, then exit to RUN with sec_clr and a tick 10 cycles later
    g = f + 14;
    h = g + 14;
    m = h + 14;
    expect_pulse(g + 6, KMin);
    expect_pulse(h + 6, KMin);
    expect_pulse(m + 7, KClr);
    expect_pulse(m + 16, KTick);
    expect_pulse(m + 26, KTick);
    at(g);
    btn_inc = 1'b1;
    at(g + 6);
    btn_inc = 1'b0;
    at(h);
    btn_inc = 1'b1;
    at(h + 6);
    btn_inc = 1'b0;
    at(m);
    btn_mode = 1'b1;
    at(m + 6);
    btn_mode = 1'b0;
    at(m + 7);
    check("mode_run_after_set_min", mode, 2'b00);
    check("blink_in_run", blink, 1'b0);

    // 5: back to SET_HOUR, then simultaneous mode+inc: mode wins, no inc pulse
    n = m + 21;
    at(n);
    btn_mode = 1'b1;
    at(n + 6);
    btn_mode = 1'b0;
    at(n + 7);
    check("mode_set_hour_again", mode, 2'b01);
    p = n + 14;
    at(p);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    at(p + 6);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check("simul_no_inc", {hour_inc, min_inc}, 2'b00);
    at(p + 7);
    check("simul_mode_wins", mode, 2'b10);

    // 6: reset in SET_MIN with inc mid-debounce; nothing fires on release
    q = p + 20;
    at(q);
    btn_inc = 1'b1;
    at(q + 3);
    check("blink_before_reset", blink, 1'b1);
    reset = 1'b0;
    #1;
    check("reset_mid_mode", mode, 2'b00);
    check("reset_mid_blink", blink, 1'b0);
    check("reset_mid_pulses", {sec_tick, sec_clr, min_inc, hour_inc}, 4'b0000);
    at(q + 6);
    reset = 1'b1;
    rr = cyc;
    expect_pulse(rr + 9, KTick);
    at(rr + 15);
    btn_inc = 1'b0;
    at(rr + 16);
    check("all_expected_pulses_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
